// File: rtl/condition_tracker.sv
// Saturating WIDTH-bit condition level with a debounced IDLE/PENDING/ACTIVE/IMMUNE FSM.
// Optional build macro DECAY_EN: hold ticks drift the level by STEP toward DEFAULT_VAL.
module condition_tracker #(
    parameter int unsigned WIDTH         = 9,
    parameter int unsigned DEFAULT_VAL   = 128,
    parameter int unsigned SET_VAL       = 128,
    parameter int unsigned STEP          = 1,
    parameter int unsigned FAST_STEP     = 4,
    parameter int unsigned ON_THRESH     = 384,
    parameter int unsigned OFF_THRESH    = 127,
    parameter int unsigned CONFIRM_TICKS = 4,
    parameter int unsigned IMMUNE_TICKS  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    input  logic             setval,
    output logic [WIDTH-1:0] value,
    output logic [1:0]       state,
    output logic             active,
    output logic             onset,
    output logic             recovered
);

    localparam int unsigned CW = $clog2(CONFIRM_TICKS + 1);
    localparam int unsigned IW = (IMMUNE_TICKS > 0) ? $clog2(IMMUNE_TICKS + 1) : 1;

    localparam logic [WIDTH-1:0] MAX_V  = '1;
    localparam logic [WIDTH-1:0] DEF_V  = WIDTH'(DEFAULT_VAL);
    localparam logic [WIDTH-1:0] SET_V  = WIDTH'(SET_VAL);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] FAST_V = WIDTH'(FAST_STEP);
    localparam logic [WIDTH-1:0] ON_V   = WIDTH'(ON_THRESH);
    localparam logic [WIDTH-1:0] OFF_V  = WIDTH'(OFF_THRESH);
    localparam logic [CW-1:0]    CONF_LAST = CW'(CONFIRM_TICKS - 1);
    localparam logic [IW-1:0]    IMM_V     = IW'(IMMUNE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_ACTIVE  = 2'b10,
        ST_IMMUNE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    conf_q, conf_d;
    logic [IW-1:0]    imm_q, imm_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             onset_q, onset_d;
    logic             rec_q, rec_d;
    logic             active_q, active_d;

    logic             inc_eff;
    logic [WIDTH-1:0] step;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            conf_q   <= '0;
            imm_q    <= '0;
            value_q  <= DEF_V;
            onset_q  <= 1'b0;
            rec_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            conf_q   <= conf_d;
            imm_q    <= imm_d;
            value_q  <= value_d;
            onset_q  <= onset_d;
            rec_q    <= rec_d;
            active_q <= active_d;
        end
    end

    // Level path: sum is one bit wider so upward saturation is a carry test.
    always_comb begin
        inc_eff = inc && (state_q != ST_IMMUNE);
        step    = fast ? FAST_V : STEP_V;
        sum     = {1'b0, value_q} + {1'b0, step};
        value_d = value_q;
        if (tick) begin
            if (setval)
                value_d = SET_V;
            else if (inc_eff && !dec)
                value_d = sum[WIDTH] ? MAX_V : sum[WIDTH-1:0];
            else if (dec && !inc_eff)
                value_d = (value_q < step) ? '0 : value_q - step;
`ifdef DECAY_EN
            else if (value_q > DEF_V)
                value_d = ((value_q - DEF_V) < STEP_V) ? DEF_V : value_q - STEP_V;
            else if (value_q < DEF_V)
                value_d = ((DEF_V - value_q) < STEP_V) ? DEF_V : value_q + STEP_V;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        conf_d  = conf_q;
        imm_d   = imm_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (value_q >= ON_V) begin
                        if (CONFIRM_TICKS <= 1) begin
                            state_d = ST_ACTIVE;
                            conf_d  = '0;
                        end else begin
                            state_d = ST_PENDING;
                            conf_d  = CW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (value_q < ON_V) begin
                        state_d = ST_IDLE;
                        conf_d  = '0;
                    end else if (conf_q >= CONF_LAST) begin
                        state_d = ST_ACTIVE;
                        conf_d  = '0;
                    end else begin
                        conf_d = conf_q + CW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (value_q <= OFF_V) begin
                        if (IMMUNE_TICKS == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_IMMUNE;
                            imm_d   = IMM_V;
                        end
                    end
                end
                ST_IMMUNE: begin
                    imm_d = (imm_q == '0) ? '0 : imm_q - IW'(1);
                    if (imm_q <= IW'(1))
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        onset_d  = (state_q != ST_ACTIVE) && (state_d == ST_ACTIVE);
        rec_d    = (state_q == ST_ACTIVE) && (state_d != ST_ACTIVE);
        active_d = (state_d == ST_ACTIVE);
    end

    assign value     = value_q;
    assign state     = state_q;
    assign active    = active_q;
    assign onset     = onset_q;
    assign recovered = rec_q;

endmodule

// File: tb/tb_condition_tracker.sv
// Self-checking bench for condition_tracker: directed vector table plus
// model-driven sequences, with expectations queued and checked after each edge.
module tb_condition_tracker;

    localparam int W       = 9;
    localparam int MAXV    = 511;
    localparam int DEF     = 128;
    localparam int SETV    = 128;
    localparam int STP     = 1;
    localparam int FSTP    = 4;
    localparam int ON_T    = 384;
    localparam int OFF_T   = 127;
    localparam int CONF_T  = 4;
    localparam int IMM_T   = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0, inc = 1'b0, dec = 1'b0, fast = 1'b0, setval = 1'b0;
    logic [W-1:0] value;
    logic [1:0]   state;
    logic         active, onset, recovered;

    condition_tracker #(
        .WIDTH(W), .DEFAULT_VAL(DEF), .SET_VAL(SETV), .STEP(STP), .FAST_STEP(FSTP),
        .ON_THRESH(ON_T), .OFF_THRESH(OFF_T), .CONFIRM_TICKS(CONF_T), .IMMUNE_TICKS(IMM_T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .inc(inc), .dec(dec), .fast(fast),
        .setval(setval), .value(value), .state(state), .active(active),
        .onset(onset), .recovered(recovered)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit t, i, d, f, s;
        int value;
        int state;
        bit onset, rec;
    } vec_t;

    typedef struct {
        int value;
        int state;
        bit active, onset, rec;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    int m_val = DEF, m_state = 0, m_conf = 0, m_imm = 0;
    bit m_on = 0, m_rec = 0;

    int onset_cnt, rec_cnt, saved;

    function automatic void model_reset();
        m_val = DEF; m_state = 0; m_conf = 0; m_imm = 0; m_on = 0; m_rec = 0;
    endfunction

    function automatic void model_step(bit t, bit i, bit d, bit f, bit s);
        int v, st, ei, stepsz;
        m_on = 0; m_rec = 0;
        if (!t) return;
        v  = m_val;
        st = m_state;
        if (st == 0) begin
            if (v >= ON_T) begin
                if (CONF_T == 1) begin m_state = 2; m_on = 1; end
                else begin m_state = 1; m_conf = 1; end
            end
        end else if (st == 1) begin
            if (v < ON_T) begin m_state = 0; m_conf = 0; end
            else begin
                m_conf++;
                if (m_conf >= CONF_T) begin m_state = 2; m_on = 1; m_conf = 0; end
            end
        end else if (st == 2) begin
            if (v <= OFF_T) begin
                m_rec = 1;
                if (IMM_T == 0) m_state = 0;
                else begin m_state = 3; m_imm = IMM_T; end
            end
        end else begin
            m_imm--;
            if (m_imm <= 0) begin m_imm = 0; m_state = 0; end
        end
        ei = (i && st != 3) ? 1 : 0;
        stepsz = f ? FSTP : STP;
        if (s) m_val = SETV;
        else if (ei == 1 && !d) m_val = (v + stepsz > MAXV) ? MAXV : v + stepsz;
        else if (ei == 0 && d)  m_val = (v - stepsz < 0) ? 0 : v - stepsz;
`ifdef DECAY_EN
        else if (v > DEF) m_val = (v - STP < DEF) ? DEF : v - STP;
        else if (v < DEF) m_val = (v + STP > DEF) ? DEF : v + STP;
`endif
    endfunction

    task automatic chk(input string name, input integer act, input integer expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic check_out(input string name);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (value !== e.value[W-1:0] || state !== e.state[1:0] || active !== e.active ||
            onset !== e.onset || recovered !== e.rec) begin
            n_bad++;
            $display("FAIL %s: got val=%0d st=%0d act=%0b on=%0b rec=%0b, expected val=%0d st=%0d act=%0b on=%0b rec=%0b",
                     name, value, state, active, onset, recovered,
                     e.value, e.state, e.active, e.onset, e.rec);
        end
    endtask

    task automatic step_io(input bit t, input bit i, input bit d, input bit f, input bit s,
                           input bit use_tbl, input vec_t tv, input string name);
        exp_t e;
        model_step(t, i, d, f, s);
        if (use_tbl) begin
            e.value = tv.value; e.state = tv.state; e.active = (tv.state == 2);
            e.onset = tv.onset; e.rec = tv.rec;
        end else begin
            e.value = m_val; e.state = m_state; e.active = (m_state == 2);
            e.onset = m_on; e.rec = m_rec;
        end
        sb.push_back(e);
        tick = t; inc = i; dec = d; fast = f; setval = s;
        @(posedge clk);
        #1;
        if (onset === 1'b1) onset_cnt++;
        if (recovered === 1'b1) rec_cnt++;
        check_out(name);
    endtask

    task automatic apply(input bit t, input bit i, input bit d, input bit f, input bit s,
                         input string name);
        vec_t dummy;
        dummy = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        step_io(t, i, d, f, s, 1'b0, dummy, name);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 1, 0, 0, 0, 128, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 0, 129, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 1, 0, 133, 0, 0, 0};
        tbl[3] = '{1, 0, 1, 0, 0, 132, 0, 0, 0};
        tbl[4] = '{1, 0, 1, 1, 0, 128, 0, 0, 0};
        tbl[5] = '{1, 0, 1, 1, 0, 124, 0, 0, 0};
        tbl[6] = '{1, 1, 0, 0, 1, 128, 0, 0, 0};
        tbl[7] = '{0, 0, 1, 0, 0, 128, 0, 0, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_value", value, DEF);
        chk("reset_state", state, 0);
        chk("reset_pulses", {active, onset, recovered}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++)
            step_io(tbl[k].t, tbl[k].i, tbl[k].d, tbl[k].f, tbl[k].s, 1'b1, tbl[k], "table");

        // Onset with debounce
        onset_cnt = 0;
        for (int k = 0; k < 64; k++) apply(1, 1, 0, 1, 0, "ramp_up");
        chk("ramp_value_384", value, 384);
        chk("ramp_still_idle", state, 0);
        for (int k = 0; k < 10 && m_state != 2; k++) apply(1, 1, 0, 1, 0, "confirm");
        chk("onset_active", active, 1);
        chk("onset_once", onset_cnt, 1);
        apply(0, 1, 0, 1, 0, "onset_drop");
        chk("onset_once_after_idle_tick", onset_cnt, 1);

        // High saturation and inc&dec hold
        for (int k = 0; k < 30; k++) apply(1, 1, 0, 1, 0, "sat_high");
        chk("sat_high_value", value, MAXV);
        apply(1, 1, 1, 1, 0, "inc_dec_hold");
`ifdef DECAY_EN
        chk("inc_dec_hold_value", value, MAXV - STP);
`else
        chk("inc_dec_hold_value", value, MAXV);
`endif

        // Recovery and immunity
        rec_cnt = 0;
        for (int k = 0; k < 200 && m_state == 2; k++) apply(1, 0, 1, 1, 0, "recover");
        chk("recovered_once", rec_cnt, 1);
        chk("immune_state", state, 3);
        saved = int'(value);
        onset_cnt = 0;
        for (int k = 0; k < IMM_T; k++) apply(1, 1, 0, 0, 0, "immune_inc");
        chk("immune_to_idle", state, 0);
        chk("immune_no_onset", onset_cnt, 0);
`ifndef DECAY_EN
        chk("immune_inc_ignored", value, saved);
`endif
        saved = int'(value);
        apply(1, 1, 0, 0, 0, "post_immune_inc");
        chk("post_immune_rise", value, saved + 1);

        // Debounce abort
        apply(1, 0, 0, 0, 1, "setval");
        onset_cnt = 0;
        for (int k = 0; k < 64; k++) apply(1, 1, 0, 1, 0, "abort_ramp");
        apply(1, 0, 1, 0, 0, "abort_dec1");
        chk("abort_pending", state, 1);
        chk("abort_value_383", value, 383);
        apply(1, 0, 1, 0, 0, "abort_dec2");
        chk("abort_idle", state, 0);
        chk("abort_no_onset", onset_cnt, 0);

        // Low saturation
        apply(1, 0, 0, 0, 1, "setval");
        for (int k = 0; k < 40; k++) apply(1, 0, 1, 1, 0, "sat_low");
        chk("sat_low_value", value, 0);

        // Hold / decay behaviour
        apply(1, 0, 0, 0, 1, "setval");
        for (int k = 0; k < 3; k++) apply(1, 1, 0, 1, 0, "to_140");
        chk("value_140", value, 140);
        for (int k = 0; k < 12; k++) apply(1, 0, 0, 0, 0, "hold");
`ifdef DECAY_EN
        chk("decay_final", value, DEF);
`else
        chk("hold_final", value, 140);
`endif

        // Asynchronous reset mid-run
        apply(1, 0, 0, 0, 1, "setval");
        for (int k = 0; k < 43; k++) apply(1, 1, 0, 1, 0, "to_300");
        chk("value_300", value, 300);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_value", value, DEF);
        chk("async_reset_state", state, 0);
        chk("async_reset_outs", {active, onset, recovered}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 1, 0, 0, 0, "post_reset_hold");
        apply(1, 1, 0, 0, 0, "post_reset_inc");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
